seq_arith_unit: RTL and testbench

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

---
 rtl/seq_arith_pkg.sv | 19 +
 rtl/seq_arith_unit_add_sub.sv | 13 +
 rtl/seq_arith_unit.sv | 161 ++++++++++++++++
 tb/tb_seq_arith_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and
// controller states.
package seq_arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ADDSUB = 2'b01,
      ST_MUL    = 2'b10,
      ST_FIN    = 2'b11
   } state_e;

endpackage

// File: rtl/seq_arith_unit_add_sub.sv
// Plain WIDTH-bit adder with carry-in; callers subtract by passing ~b and cin=1.
module add_sub_nbit #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential ADD/SUB/MUL unit: single-cycle add/sub, W-step radix-2 shift-add
// multiply, both sharing one W+1-bit adder.
module seq_arith_unit
   import seq_arith_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic [1:0]     OP,
   input  logic           C,
   input  logic [W-1:0]   A_IN,
   input  logic [W-1:0]   B_IN,
   output logic [2*W-1:0] RESULT,
   output logic           BUSY,
   output logic           DONE,
   output logic           P,
   output logic           N,
   output logic           ERR
);

   localparam int CW = $clog2(W);

   state_e         state, state_n, start_state;
   op_e            op_q;
   logic           c_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W:0]     hi_q;
   logic [CW-1:0]  cnt_q;

   logic           accept, last_step, busy;
   logic           err_set, err_clr;
   logic [W:0]     a_ext, b_ext;
   logic [W:0]     add_a, add_b, sum;
   logic           add_cin;
   logic [W:0]     hi_n;
   logic [W-1:0]   lo_n;
   logic [2*W-1:0] as_result;
   logic           as_p, as_n;

   assign accept      = START && (state == ST_IDLE || state == ST_FIN);
   assign last_step   = (cnt_q == CW'(W-1));
   assign start_state = (OP == OP_MUL) ? ST_MUL : ST_ADDSUB;

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      DONE    = 1'b0;
      case (state)
         ST_IDLE:   if (START) state_n = start_state;
         ST_ADDSUB: begin
            busy    = 1'b1;
            state_n = ST_FIN;
         end
         ST_MUL: begin
            busy = 1'b1;
            if (last_step) state_n = ST_FIN;
         end
         ST_FIN: begin
            DONE    = 1'b1;
            state_n = START ? start_state : ST_IDLE;
         end
         default:   state_n = ST_IDLE;
      endcase
   end

   assign BUSY = busy;

   // Adder operand selection: operands are extended by one bit per latched mode
   // so the W+1-bit sum carries the unsigned carry/borrow or exact signed value.
   always_comb begin
      a_ext   = c_q ? {a_q[W-1], a_q} : {1'b0, a_q};
      b_ext   = c_q ? {b_q[W-1], b_q} : {1'b0, b_q};
      add_a   = a_ext;
      add_b   = b_ext;
      add_cin = 1'b0;
      if (state == ST_MUL) begin
         add_a = hi_q;
         add_b = '0;
         if (b_q[0]) begin
            if (c_q && last_step) begin
               add_b   = ~a_ext;
               add_cin = 1'b1;
            end else begin
               add_b = a_ext;
            end
         end
      end else if (op_q == OP_SUB) begin
         add_b   = ~b_ext;
         add_cin = 1'b1;
      end
   end

   add_sub_nbit #(.WIDTH(W + 1)) u_add (
      .a   (add_a),
      .b   (add_b),
      .cin (add_cin),
      .sum (sum)
   );

   always_comb begin
      hi_n      = {c_q & sum[W], sum[W:1]};
      lo_n      = {sum[0], b_q[W-1:1]};
      as_result = c_q ? {{W{sum[W-1]}}, sum[W-1:0]} : {{W{1'b0}}, sum[W-1:0]};
      if (c_q) begin
         as_p = sum[W] ^ sum[W-1];
         as_n = sum[W-1];
      end else begin
         as_p = (op_q == OP_ADD) & sum[W];
         as_n = (op_q == OP_SUB) & sum[W];
      end
   end

   assign err_set = (busy && (C != c_q)) || (state == ST_ADDSUB && op_q == OP_RSV);
   assign err_clr = accept && (OP != OP_RSV);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q  <= '0;
         RESULT <= '0;
         P      <= 1'b0;
         N      <= 1'b0;
         ERR    <= 1'b0;
      end else begin
         ERR <= err_set | (ERR & ~err_clr);
         if (accept)              cnt_q <= '0;
         else if (state == ST_MUL) cnt_q <= last_step ? '0 : cnt_q + CW'(1);
         if (state == ST_ADDSUB && op_q != OP_RSV) begin
            RESULT <= as_result;
            P      <= as_p;
            N      <= as_n;
         end else if (state == ST_MUL && last_step) begin
            RESULT <= {hi_n[W-1:0], lo_n};
            P      <= 1'b0;
            N      <= c_q & hi_n[W-1];
         end
      end
   end

   // Operand/partial-product registers carry no reset; they are reloaded on accept.
   always_ff @(posedge CLK) begin
      if (accept) begin
         a_q  <= A_IN;
         b_q  <= B_IN;
         op_q <= op_e'(OP);
         c_q  <= C;
         hi_q <= '0;
      end else if (state == ST_MUL) begin
         hi_q <= hi_n;
         b_q  <= lo_n;
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit (W=16): arithmetic reference model feeds
// an expectation queue that a DONE-driven monitor drains.
module tb_seq_arith_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [1:0]  OP = 2'b00;
   logic        C = 1'b0;
   logic [15:0] A_IN = '0;
   logic [15:0] B_IN = '0;
   logic [31:0] RESULT;
   logic        BUSY, DONE, P, N, ERR;

   seq_arith_unit #(.W(16)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP), .C(C),
      .A_IN(A_IN), .B_IN(B_IN), .RESULT(RESULT), .BUSY(BUSY),
      .DONE(DONE), .P(P), .N(N), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] res;
      logic        p;
      logic        n;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          busy_cnt = 0;
   logic [31:0] m_res = '0;
   logic        m_p = 1'b0, m_n = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: results from plain integer arithmetic on the operands.
   task automatic model(input logic [1:0] op, input logic c, input logic [15:0] a,
                        input logic [15:0] b, input bit tog, output exp_t e);
      longint x, y, s;
      logic [15:0] r16;
      logic [63:0] s64;
      x = c ? longint'($signed(a)) : longint'(a);
      y = c ? longint'($signed(b)) : longint'(b);
      e.err = 1'b1;
      case (op)
         2'd0, 2'd1: begin
            s   = (op == 2'd0) ? x + y : x - y;
            s64 = s;
            r16 = s64[15:0];
            if (c) begin
               m_p   = (s > 32767) || (s < -32768);
               m_n   = r16[15];
               m_res = {{16{r16[15]}}, r16};
            end else begin
               m_p   = (op == 2'd0) && (s > 65535);
               m_n   = (op == 2'd1) && (s < 0);
               m_res = {16'h0000, r16};
            end
            e.err = tog;
         end
         2'd2: begin
            s     = x * y;
            s64   = s;
            m_res = s64[31:0];
            m_p   = 1'b0;
            m_n   = c && (s < 0);
            e.err = tog;
         end
         default: ;
      endcase
      e.res = m_res;
      e.p   = m_p;
      e.n   = m_n;
      e.lat = (op == 2'd2) ? 16 : 1;
      e.acc = 0;
   endtask

   // Monitor: every DONE pops one expectation and checks result, flags, latency, BUSY length.
   always @(negedge CLK) begin
      exp_t e;
      if (BUSY) busy_cnt++;
      if (DONE) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: DONE with no pending operation (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            check("result", RESULT, e.res);
            check("flag_p", P, e.p);
            check("flag_n", N, e.n);
            check("err", ERR, e.err);
            check("done_latency", cyc - e.acc, e.lat);
            check("busy_cycles", busy_cnt, e.lat);
         end
         busy_cnt = 0;
      end else if (!BUSY) begin
         busy_cnt = 0;
      end
   end

   task automatic issue(input logic [1:0] op, input logic c, input logic [15:0] a,
                        input logic [15:0] b, input bit tog, input bit push);
      exp_t e;
      START = 1'b1; OP = op; C = c; A_IN = a; B_IN = b;
      @(posedge CLK); #1;
      if (push) begin
         model(op, c, a, b, tog, e);
         e.acc = cyc;
         q.push_back(e);
      end
      @(negedge CLK);
      START = 1'b0; A_IN = 16'($urandom); B_IN = 16'($urandom); OP = 2'($urandom);
   endtask

   task automatic wait_done(input int tog_at, input bit poke);
      int n = 0;
      while (DONE !== 1'b1 && n < 40) begin
         if (n == tog_at) C = ~C;
         START = poke && (n == 5);
         if (START) begin
            A_IN = 16'($urandom); B_IN = 16'($urandom); OP = 2'($urandom);
         end
         @(negedge CLK);
         n++;
      end
      START = 1'b0;
      total++;
      if (DONE !== 1'b1) begin
         bad++;
         $display("FAIL done_timeout: no DONE within %0d cycles", n);
      end
   endtask

   function automatic logic [15:0] pick();
      logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 4)];
      return 16'($urandom);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  op;
      logic        c;
      logic [15:0] a, b;
      bit          tog, poke;

      repeat (3) @(negedge CLK);
      check("rst_result", RESULT, 0);
      check("rst_p", P, 0);
      check("rst_n", N, 0);
      check("rst_err", ERR, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      RST = 1'b0;
      @(negedge CLK);

      issue(2'd0, 1'b0, 16'hFFFF, 16'h0001, 0, 1); wait_done(-1, 0);
      issue(2'd1, 1'b1, 16'h8000, 16'h0001, 0, 1); wait_done(-1, 0);
      issue(2'd1, 1'b0, 16'h0001, 16'h0002, 0, 1); wait_done(-1, 0);
      @(negedge CLK);
      issue(2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 0, 1); wait_done(-1, 1);
      issue(2'd2, 1'b1, 16'hFFFE, 16'h0003, 0, 1); wait_done(-1, 0);
      issue(2'd2, 1'b1, 16'h8000, 16'h8000, 0, 1); wait_done(-1, 1);
      @(negedge CLK);
      issue(2'd2, 1'b1, 16'hFFFE, 16'h0003, 1, 1); wait_done(4, 0);
      issue(2'd0, 1'b0, 16'h1111, 16'h2222, 0, 1); wait_done(-1, 0);
      issue(2'd3, 1'b0, 16'h5555, 16'h5555, 0, 1); wait_done(-1, 0);
      issue(2'd1, 1'b0, 16'h0010, 16'h0003, 1, 1); wait_done(0, 0);
      @(negedge CLK);

      // Abort a multiply after seven iterations with ERR already set.
      issue(2'd2, 1'b1, 16'h1234, 16'h5678, 0, 0);
      C = ~C;
      repeat (6) @(negedge CLK);
      check("busy_before_rst", BUSY, 1);
      check("err_before_rst", ERR, 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      check("abort_result", RESULT, 0);
      check("abort_p", P, 0);
      check("abort_n", N, 0);
      check("abort_err", ERR, 0);
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      m_res = '0; m_p = 1'b0; m_n = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      issue(2'd0, 1'b0, 16'h0003, 16'h0004, 0, 1); wait_done(-1, 0);

      for (int i = 0; i < 40; i++) begin
         op   = ($urandom_range(0, 9) < 4) ? 2'd2 : 2'($urandom_range(0, 3));
         c    = 1'($urandom);
         a    = pick();
         b    = pick();
         tog  = ($urandom_range(0, 5) == 0);
         poke = ($urandom_range(0, 3) == 0) && (op == 2'd2);
         issue(op, c, a, b, tog, 1);
         wait_done(tog ? ((op == 2'd2) ? 4 : 0) : -1, poke);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
